// File: rtl/ps2_keymap_tracker.sv
// PS/2 scan-code set-2 key tracker.
// Decodes E0 (extended) and F0 (break) prefixes into make/break events and keeps
// a held bit per configured key, with press/release pulses, a prefix timeout and
// an optional last-pressed-wins mode.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | no prefix pending; next plain byte is a non-extended make
// EXT      | E0 seen; next byte is an extended make (or F0)
// BRK      | F0 seen; next byte is a non-extended break
// EXT_BRK  | E0 F0 seen; next byte is an extended break
module ps2_keymap_tracker #(
   parameter int                       NUM_KEYS       = 3,
   parameter logic [NUM_KEYS*9-1:0]    KEY_CODES      = {9'h175, 9'h16B, 9'h174},
   parameter int                       TIMEOUT_CYCLES = 50000,
   parameter bit                       EXCLUSIVE      = 1'b0
) (
   input  logic                  Clock,
   input  logic                  Resetn,
   input  logic                  clear,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [NUM_KEYS-1:0]   key_held,
   output logic [NUM_KEYS-1:0]   key_press_pulse,
   output logic [NUM_KEYS-1:0]   key_release_pulse,
   output logic                  proto_error
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   state_t                state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [NUM_KEYS-1:0]   held_q;
   logic [NUM_KEYS-1:0]   press_q;
   logic [NUM_KEYS-1:0]   release_q;
   logic                  err_q;

   logic                  code_ext;
   logic [NUM_KEYS-1:0]   match;
   logic [NUM_KEYS-1:0]   make_held_d;
   logic [NUM_KEYS-1:0]   make_press_d;
   logic [NUM_KEYS-1:0]   brk_held_d;
   logic [NUM_KEYS-1:0]   brk_release_d;

   assign code_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

   // Compare the current byte (tagged with the pending E0 prefix) against every slot.
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         match[i] = (KEY_CODES[9*i +: 9] == {code_ext, rx_data});
      end
   end

   // Candidate held/pulse values for a make or a break of the current byte.
   // In exclusive mode a matching make replaces the whole held vector; a
   // non-matching code must leave it alone, hence the match check.
   always_comb begin
      make_press_d  = match & ~held_q;
      if (EXCLUSIVE) begin
         make_held_d = (match != '0) ? match : held_q;
      end else begin
         make_held_d = held_q | match;
      end
      brk_release_d = held_q & match;
      brk_held_d    = held_q & ~match;
   end

   // Prefix FSM, timeout counter and registered outputs.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         held_q    <= '0;
         press_q   <= '0;
         release_q <= '0;
         err_q     <= 1'b0;
      end else begin
         press_q   <= '0;
         release_q <= '0;
         err_q     <= 1'b0;
         if (clear) begin
            held_q  <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
         end else if (rx_valid) begin
            // A byte always restarts the idle timer, even on the expiry cycle.
            cnt_q <= '0;
            unique case (state_q)
               ST_IDLE: begin
                  if (rx_data == BYTE_EXT) begin
                     state_q <= ST_EXT;
                  end else if (rx_data == BYTE_BRK) begin
                     state_q <= ST_BRK;
                  end else begin
                     held_q  <= make_held_d;
                     press_q <= make_press_d;
                  end
               end
               ST_EXT: begin
                  if (rx_data == BYTE_BRK) begin
                     state_q <= ST_EXT_BRK;
                  end else if (rx_data == BYTE_EXT) begin
                     err_q   <= 1'b1;
                  end else begin
                     held_q  <= make_held_d;
                     press_q <= make_press_d;
                     state_q <= ST_IDLE;
                  end
               end
               ST_BRK, ST_EXT_BRK: begin
                  if ((rx_data == BYTE_EXT) || (rx_data == BYTE_BRK)) begin
                     err_q <= 1'b1;
                  end else begin
                     held_q    <= brk_held_d;
                     release_q <= brk_release_d;
                  end
                  state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_LAST) begin
               state_q <= ST_IDLE;
               err_q   <= 1'b1;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign key_held          = held_q;
   assign key_press_pulse   = press_q;
   assign key_release_pulse = release_q;
   assign proto_error       = err_q;

endmodule

// File: tb/tb_ps2_keymap_tracker.sv
// Bench for ps2_keymap_tracker: two instances (default, and exclusive with a
// 16-cycle timeout) driven by the same byte stream and checked against a
// prefix-flag reference model, plus a vector table and directed corner cases.
module tb_ps2_keymap_tracker;

   logic       Clock;
   logic       Resetn;
   logic       clear;
   logic [7:0] rx_data;
   logic       rx_valid;

   logic [2:0] held0, press0, rel0;
   logic       err0;
   logic [2:0] held1, press1, rel1;
   logic       err1;

   int n_cmp;
   int n_bad;

   ps2_keymap_tracker u_def (
      .Clock(Clock), .Resetn(Resetn), .clear(clear), .rx_data(rx_data), .rx_valid(rx_valid),
      .key_held(held0), .key_press_pulse(press0), .key_release_pulse(rel0), .proto_error(err0)
   );

   ps2_keymap_tracker #(.TIMEOUT_CYCLES(16), .EXCLUSIVE(1'b1)) u_ex (
      .Clock(Clock), .Resetn(Resetn), .clear(clear), .rx_data(rx_data), .rx_valid(rx_valid),
      .key_held(held1), .key_press_pulse(press1), .key_release_pulse(rel1), .proto_error(err1)
   );

   // Free-running system clock.
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ---------------- reference model ----------------
   logic [8:0] keys [3] = '{9'h174, 9'h16B, 9'h175};
   int         m_tmo [2] = '{50000, 16};
   bit         m_exc [2] = '{1'b0, 1'b1};

   logic [2:0] m_held  [2];
   logic [2:0] m_press [2];
   logic [2:0] m_rel   [2];
   bit         m_err   [2];
   bit         m_ext   [2];
   bit         m_brk   [2];
   int         m_idle  [2];

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_held[p] = '0; m_press[p] = '0; m_rel[p] = '0; m_err[p] = 1'b0;
         m_ext[p] = 1'b0; m_brk[p] = 1'b0; m_idle[p] = 0;
      end
   endtask

   task automatic model_update(input bit c, input bit v, input logic [7:0] d);
      logic [2:0] mask;
      for (int p = 0; p < 2; p++) begin
         m_press[p] = '0; m_rel[p] = '0; m_err[p] = 1'b0;
         if (c) begin
            m_held[p] = '0; m_ext[p] = 1'b0; m_brk[p] = 1'b0; m_idle[p] = 0;
         end else if (v) begin
            m_idle[p] = 0;
            if (d == 8'hE0) begin
               if (m_brk[p]) begin
                  m_err[p] = 1'b1; m_ext[p] = 1'b0; m_brk[p] = 1'b0;
               end else if (m_ext[p]) m_err[p] = 1'b1;
               else m_ext[p] = 1'b1;
            end else if (d == 8'hF0) begin
               if (m_brk[p]) begin
                  m_err[p] = 1'b1; m_ext[p] = 1'b0; m_brk[p] = 1'b0;
               end else m_brk[p] = 1'b1;
            end else begin
               mask = '0;
               for (int k = 0; k < 3; k++) if (keys[k] == {m_ext[p], d}) mask[k] = 1'b1;
               if (m_brk[p]) begin
                  m_rel[p]  = m_held[p] & mask;
                  m_held[p] = m_held[p] & ~mask;
               end else if (mask != 0) begin
                  m_press[p] = mask & ~m_held[p];
                  m_held[p]  = m_exc[p] ? mask : (m_held[p] | mask);
               end
               m_ext[p] = 1'b0; m_brk[p] = 1'b0;
            end
         end else if (m_ext[p] || m_brk[p]) begin
            m_idle[p]++;
            if (m_idle[p] == m_tmo[p]) begin
               m_err[p] = 1'b1; m_ext[p] = 1'b0; m_brk[p] = 1'b0; m_idle[p] = 0;
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_models();
      chk("model def {held,press,rel,err}", {22'd0, held0, press0, rel0, err0},
          {22'd0, m_held[0], m_press[0], m_rel[0], m_err[0]});
      chk("model ex {held,press,rel,err}", {22'd0, held1, press1, rel1, err1},
          {22'd0, m_held[1], m_press[1], m_rel[1], m_err[1]});
   endtask

   task automatic step(input bit c, input bit v, input logic [7:0] d);
      clear = c; rx_valid = v; rx_data = d;
      @(posedge Clock);
      model_update(c, v, d);
      #1;
      check_models();
   endtask

   typedef struct {
      bit         c;
      bit         v;
      logic [7:0] d;
      logic [2:0] held;
      logic [2:0] press;
      logic [2:0] rel;
      bit         err;
   } vec_t;

   vec_t vecs [$];

   task automatic add(input bit c, input bit v, input logic [7:0] d,
                      input logic [2:0] h, input logic [2:0] pr, input logic [2:0] r, input bit e);
      vec_t t;
      t.c = c; t.v = v; t.d = d; t.held = h; t.press = pr; t.rel = r; t.err = e;
      vecs.push_back(t);
   endtask

   logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h74, 8'h1C, 8'hE1, 8'hAA};

   // Stimulus and directed checks.
   initial begin
      n_cmp = 0; n_bad = 0;
      Resetn = 1'b0; clear = 1'b0; rx_valid = 1'b0; rx_data = '0;
      model_reset();

      // Expected outputs of the default instance, one row per clock.
      add(0,1,8'hE0, 3'b000,3'b000,3'b000,0);
      add(0,1,8'h75, 3'b100,3'b100,3'b000,0);
      add(0,0,8'h00, 3'b100,3'b000,3'b000,0);
      add(0,1,8'hE0, 3'b100,3'b000,3'b000,0);
      add(0,1,8'hF0, 3'b100,3'b000,3'b000,0);
      add(0,1,8'h75, 3'b000,3'b000,3'b100,0);
      add(0,0,8'h00, 3'b000,3'b000,3'b000,0);
      add(0,1,8'hE0, 3'b000,3'b000,3'b000,0);
      add(0,1,8'h75, 3'b100,3'b100,3'b000,0);
      add(0,1,8'hE0, 3'b100,3'b000,3'b000,0);
      add(0,1,8'h75, 3'b100,3'b000,3'b000,0);
      add(0,1,8'hE0, 3'b100,3'b000,3'b000,0);
      add(0,1,8'h75, 3'b100,3'b000,3'b000,0);
      add(0,1,8'hF0, 3'b100,3'b000,3'b000,0);
      add(0,1,8'hF0, 3'b100,3'b000,3'b000,1);
      add(0,1,8'h1C, 3'b100,3'b000,3'b000,0);
      add(0,0,8'h00, 3'b100,3'b000,3'b000,0);
      add(0,1,8'h74, 3'b100,3'b000,3'b000,0);
      add(0,1,8'hE0, 3'b100,3'b000,3'b000,0);
      add(0,1,8'h6B, 3'b110,3'b010,3'b000,0);
      add(0,1,8'hE0, 3'b110,3'b000,3'b000,0);
      add(0,1,8'hE0, 3'b110,3'b000,3'b000,1);
      add(0,1,8'h74, 3'b111,3'b001,3'b000,0);
      add(0,1,8'hE1, 3'b111,3'b000,3'b000,0);
      add(0,1,8'hF0, 3'b111,3'b000,3'b000,0);
      add(0,1,8'hE0, 3'b111,3'b000,3'b000,1);
      add(0,1,8'h6B, 3'b111,3'b000,3'b000,0);
      add(1,1,8'hE0, 3'b000,3'b000,3'b000,0);
      add(0,1,8'hE0, 3'b000,3'b000,3'b000,0);
      add(0,1,8'hF0, 3'b000,3'b000,3'b000,0);
      add(0,1,8'h75, 3'b000,3'b000,3'b000,0);
      add(0,1,8'hE0, 3'b000,3'b000,3'b000,0);
      add(1,0,8'h00, 3'b000,3'b000,3'b000,0);
      add(0,1,8'h75, 3'b000,3'b000,3'b000,0);

      #12;
      chk("reset def outputs", {22'd0, held0, press0, rel0, err0}, 32'd0);
      chk("reset ex outputs",  {22'd0, held1, press1, rel1, err1}, 32'd0);
      #5 Resetn = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].c, vecs[i].v, vecs[i].d);
         chk($sformatf("vec %0d def {held,press,rel,err}", i),
             {22'd0, held0, press0, rel0, err0},
             {22'd0, vecs[i].held, vecs[i].press, vecs[i].rel, vecs[i].err});
      end

      // Exclusive mode: a new make takes over without a release pulse.
      step(1,0,8'h00);
      step(0,1,8'hE0); step(0,1,8'h75);
      chk("excl first make held", {29'd0, held1}, 32'b100);
      step(0,1,8'hE0); step(0,1,8'h6B);
      chk("excl second make held", {29'd0, held1}, 32'b010);
      chk("excl no release pulse", {29'd0, rel1}, 32'd0);

      // Timeout after 16 silent cycles; the following byte is non-extended.
      step(0,1,8'hE0);
      for (int k = 1; k < 16; k++) begin
         step(0,0,8'h00);
         chk("no early timeout", {31'd0, err1}, 32'd0);
      end
      step(0,0,8'h00);
      chk("timeout error", {31'd0, err1}, 32'd1);
      step(0,0,8'h00);
      chk("timeout pulse one cycle", {31'd0, err1}, 32'd0);
      step(0,1,8'h75);
      chk("after timeout held", {29'd0, held1}, 32'b010);
      chk("after timeout no press", {29'd0, press1}, 32'd0);

      // Byte arriving on the expiry cycle wins.
      step(0,1,8'hE0);
      for (int k = 1; k < 16; k++) step(0,0,8'h00);
      step(0,1,8'h75);
      chk("expiry byte press", {29'd0, press1}, 32'b100);
      chk("expiry byte no error", {31'd0, err1}, 32'd0);

      // Async reset in the middle of a break sequence.
      step(0,1,8'hE0); step(0,1,8'h6B);
      step(0,1,8'hE0); step(0,1,8'hF0);
      #2 Resetn = 1'b0;
      #1;
      chk("async reset def", {22'd0, held0, press0, rel0, err0}, 32'd0);
      chk("async reset ex",  {22'd0, held1, press1, rel1, err1}, 32'd0);
      model_reset();
      #1 Resetn = 1'b1;
      step(0,1,8'h75);
      step(0,1,8'hE0); step(0,1,8'h75);
      step(1,0,8'h00);
      chk("clear held", {26'd0, held0, held1}, 32'd0);
      chk("clear no pulses", {20'd0, press0, rel0, press1, rel1}, 32'd0);

      // Randomised traffic checked only against the model.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 3) begin
            for (int k = $urandom_range(10, 20); k > 0; k--) step(0,0,8'h00);
         end else if ($urandom_range(0, 99) < 2) begin
            step(1, $urandom_range(0,1), pool[$urandom_range(0,7)]);
         end else if ($urandom_range(0, 99) < 60) begin
            if ($urandom_range(0, 7) == 0) step(0,1,8'($urandom));
            else step(0,1,pool[$urandom_range(0,7)]);
         end else begin
            step(0,0,8'($urandom));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
